// File: rtl/mem_pkg.sv
// mem_pkg: op encodings, sequencer FSM states and memory geometry defaults
// shared by the stack sequencer and its bench.
package mem_pkg;

    localparam int MEM_AW    = 10;
    localparam int MEM_DEPTH = 1024;

    typedef enum logic [2:0] {
        OP_LW   = 3'd0,
        OP_SW   = 3'd1,
        OP_PUSH = 3'd2,
        OP_POP  = 3'd3,
        OP_CALL = 3'd4,
        OP_RET  = 3'd5
    } op_e;

    typedef enum logic [1:0] {
        IDLE,
        XFER,
        RDLAST,
        DONE
    } state_e;

    function automatic logic op_writes(input logic [2:0] op);
        return op == OP_SW || op == OP_PUSH || op == OP_CALL;
    endfunction

    function automatic logic op_pushes(input logic [2:0] op);
        return op == OP_PUSH || op == OP_CALL;
    endfunction

    function automatic logic op_pops(input logic [2:0] op);
        return op == OP_POP || op == OP_RET;
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// rr_arbiter2: two-way round-robin arbiter; on a tie the requester not granted
// last wins, and requester 0 is favoured out of reset.
module rr_arbiter2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req_i,
    input  logic       en_i,
    output logic [1:0] gnt_o
);

    logic last_q;

    assign gnt_o[0] = en_i && req_i[0] && (!req_i[1] || last_q);
    assign gnt_o[1] = en_i && req_i[1] && (!req_i[0] || !last_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            last_q <= 1'b1;
        else if (|gnt_o)
            last_q <= gnt_o[1];
    end

endmodule

// File: rtl/mem_stack_sequencer.sv
// mem_stack_sequencer: arbitrates CPU and debug word requests and sequences each as
// four little-endian byte accesses on a synchronous byte memory, with a hardware stack.
module mem_stack_sequencer
    import mem_pkg::*;
#(
    parameter int AW    = MEM_AW,
    parameter int DEPTH = MEM_DEPTH
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cpu_req,
    input  logic [2:0]    cpu_op,
    input  logic [31:0]   cpu_addr,
    input  logic [31:0]   cpu_wdata,
    input  logic [31:0]   cpu_pc,
    output logic          cpu_ack,
    output logic [31:0]   cpu_rdata,
    output logic          cpu_err,
    input  logic          dbg_req,
    input  logic          dbg_we,
    input  logic [31:0]   dbg_addr,
    input  logic [31:0]   dbg_wdata,
    output logic          dbg_ack,
    output logic [31:0]   dbg_rdata,
    output logic [AW-1:0] mem_addr,
    output logic          mem_we,
    output logic [7:0]    mem_wdata,
    input  logic [7:0]    mem_rdata,
    output logic [AW:0]   sp,
    output logic          busy,
    output logic          stack_err
);

    localparam logic [AW:0]   SP_TOP    = (AW+1)'(DEPTH);
    localparam logic [AW:0]   SP_STEP   = (AW+1)'(4);
    localparam logic [AW-1:0] BASE_STEP = (AW)'(4);

    state_e        state_q, state_d;
    logic [1:0]    k_q, k_d;
    logic [AW-1:0] base_q, base_d;
    logic [31:0]   word_q, word_d;
    logic [2:0]    op_q, op_d;
    logic          own_q, own_d;
    logic          err_q, err_d;
    logic          stack_err_q, stack_err_d;
    logic [AW:0]   sp_q, sp_d;
    logic [31:0]   cpu_rdata_q, cpu_rdata_d;
    logic [31:0]   dbg_rdata_q, dbg_rdata_d;

    logic [1:0]    gnt;
    logic [2:0]    req_op;
    logic [31:0]   req_addr, req_word;
    logic [AW-1:0] req_base;
    logic          req_push, req_pop, ovf, unf, req_err;

    rr_arbiter2 u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .req_i ({dbg_req, cpu_req}),
        .en_i  (state_q == IDLE),
        .gnt_o (gnt)
    );

    // Debug accesses ride the LW/SW paths so one datapath serves both requesters.
    assign req_op   = gnt[1] ? (dbg_we ? OP_SW : OP_LW) : cpu_op;
    assign req_addr = gnt[1] ? dbg_addr : cpu_addr;
    assign req_word = gnt[1] ? dbg_wdata : (cpu_op == OP_CALL ? cpu_pc + 32'd1 : cpu_wdata);
    assign req_push = op_pushes(req_op);
    assign req_pop  = op_pops(req_op);
    assign ovf      = req_push && sp_q < SP_STEP;
    assign unf      = req_pop && sp_q == SP_TOP;
    assign req_err  = req_op > OP_RET || ovf || unf ||
                      (!req_push && !req_pop && (req_addr[1:0] != 2'd0 || req_addr[31:AW] != '0));
    assign req_base = req_push ? sp_q[AW-1:0] - BASE_STEP : req_pop ? sp_q[AW-1:0] : req_addr[AW-1:0];

    assign mem_addr  = base_q + {{(AW-2){1'b0}}, k_q};
    assign mem_we    = state_q == XFER && op_writes(op_q);
    assign mem_wdata = word_q[{k_q, 3'b000} +: 8];
    assign busy      = state_q != IDLE;
    assign cpu_ack   = state_q == DONE && !own_q;
    assign dbg_ack   = state_q == DONE && own_q;
    assign cpu_err   = cpu_ack && err_q;
    assign cpu_rdata = cpu_rdata_q;
    assign dbg_rdata = dbg_rdata_q;
    assign sp        = sp_q;
    assign stack_err = stack_err_q;

    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        base_d      = base_q;
        word_d      = word_q;
        op_d        = op_q;
        own_d       = own_q;
        err_d       = err_q;
        stack_err_d = stack_err_q;
        sp_d        = sp_q;
        cpu_rdata_d = cpu_rdata_q;
        dbg_rdata_d = dbg_rdata_q;
        case (state_q)
            IDLE: if (|gnt) begin
                op_d        = req_op;
                own_d       = gnt[1];
                base_d      = req_base;
                word_d      = req_word;
                err_d       = req_err;
                k_d         = 2'd0;
                stack_err_d = stack_err_q || ovf || unf;
                state_d     = req_err ? DONE : XFER;
            end
            XFER: begin
                k_d = k_q + 2'd1;
                // Read data trails the address by one cycle, so byte k-1 lands at step k.
                if (!op_writes(op_q) && k_q != 2'd0)
                    word_d[{k_q - 2'd1, 3'b000} +: 8] = mem_rdata;
                if (k_q == 2'd3)
                    state_d = op_writes(op_q) ? DONE : RDLAST;
            end
            RDLAST: begin
                word_d[31:24] = mem_rdata;
                cpu_rdata_d   = own_q ? cpu_rdata_q : {mem_rdata, word_q[23:0]};
                dbg_rdata_d   = own_q ? {mem_rdata, word_q[23:0]} : dbg_rdata_q;
                state_d       = DONE;
            end
            DONE: begin
                state_d = IDLE;
                k_d     = 2'd0;
                if (!err_q)
                    sp_d = op_pushes(op_q) ? sp_q - SP_STEP : op_pops(op_q) ? sp_q + SP_STEP : sp_q;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            k_q         <= 2'd0;
            base_q      <= '0;
            word_q      <= '0;
            op_q        <= 3'd0;
            own_q       <= 1'b0;
            err_q       <= 1'b0;
            stack_err_q <= 1'b0;
            sp_q        <= SP_TOP;
            cpu_rdata_q <= '0;
            dbg_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            base_q      <= base_d;
            word_q      <= word_d;
            op_q        <= op_d;
            own_q       <= own_d;
            err_q       <= err_d;
            stack_err_q <= stack_err_d;
            sp_q        <= sp_d;
            cpu_rdata_q <= cpu_rdata_d;
            dbg_rdata_q <= dbg_rdata_d;
        end
    end

endmodule
